aud_dac_player: RTL and testbench

AUD_DAC_PLAYER -- requirements
Module: aud_dac_player

---
 rtl/aud_pkg.sv | 16 +
 rtl/aud_bclk_gen.sv | 32 +++
 rtl/aud_dac_player.sv | 165 ++++++++++++++++
 tb/tb_aud_dac_player.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aud_pkg.sv
// Shared types and constants for the audio DAC player.
// Holds the player state encoding, the default bit-clock divider and the half-frame length.
package aud_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        LEFT,
        RIGHT,
        DONE
    } aud_state_e;

    localparam int BCLK_DIV  = 48;
    localparam int HALF_BITS = 16;

endpackage

// File: rtl/aud_bclk_gen.sv
// Free-running codec bit-clock generator.
// Drives BCLK low for the first half of each period, high for the second, and pulses tick on the falling edge.
module aud_bclk_gen #(
    parameter int BCLK_DIV = aud_pkg::BCLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    output logic bclk,
    output logic tick
);

    localparam int CW = $clog2(BCLK_DIV);
    localparam logic [CW-1:0] HALF = CW'(BCLK_DIV / 2);
    localparam logic [CW-1:0] LAST = CW'(BCLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bclk = (cnt >= HALF);
    // tick marks the last count, so flops updated on it change together with BCLK falling
    assign tick = (cnt == LAST);

endmodule

// File: rtl/aud_dac_player.sv
// Plays samples from memory range [AUD_ADDR1, AUD_ADDR2) to an I2S-style codec, one sample per frame.
// Build option AUD_MONO_DUP_EN: right half repeats the left sample; otherwise the right half is zero.
module aud_dac_player #(
    parameter int SAMPLE_W = 16,
    parameter int ADDR_W   = 18,
    parameter int BCLK_DIV = aud_pkg::BCLK_DIV
) (
    input  logic                MCLK,
    input  logic                reset,
    input  logic                enable,
    input  logic [ADDR_W-1:0]   AUD_ADDR1,
    input  logic [ADDR_W-1:0]   AUD_ADDR2,
    output logic [ADDR_W-1:0]   MEM_ADDR,
    output logic                MEM_RD,
    input  logic [SAMPLE_W-1:0] MEM_DATA,
    output logic                AUD_BCLK,
    output logic                AUD_DACLRCK,
    output logic                AUD_DACDAT,
    output logic                busy,
    output logic                done
);

    import aud_pkg::*;

    localparam int CNT_W = $clog2(HALF_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(HALF_BITS - 1);

    aud_state_e          state, state_next;
    logic                tick;
    logic [ADDR_W-1:0]   ptr, end_addr;
    logic                loaded, prefetched, rd_d1;
    logic [SAMPLE_W-1:0] sample_buf, shreg;
    logic [CNT_W-1:0]    bit_cnt;
    logic                start, enter_left, enter_right, shift, stop;
`ifdef AUD_MONO_DUP_EN
    logic [SAMPLE_W-1:0] cur;
`endif

    aud_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk (
        .clk   (MCLK),
        .rst_n (reset),
        .bclk  (AUD_BCLK),
        .tick  (tick)
    );

    always_ff @(posedge MCLK or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (tick) begin
            case (state)
                IDLE:  if (enable) state_next = (loaded || (AUD_ADDR1 < AUD_ADDR2)) ? PRIME : DONE;
                PRIME: state_next = LEFT;
                LEFT:  if (bit_cnt == LAST_BIT) state_next = RIGHT;
                RIGHT: if (bit_cnt == LAST_BIT) begin
                           if (prefetched)           state_next = LEFT;
                           else if (ptr == end_addr) state_next = DONE;
                           else                      state_next = IDLE;
                       end
                DONE:  if (!enable) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    assign start       = tick && (state == IDLE) && enable;
    assign enter_left  = tick && (state != LEFT) && (state_next == LEFT);
    assign enter_right = tick && (state == LEFT) && (state_next == RIGHT);
    assign shift       = tick && (state == state_next) && ((state == LEFT) || (state == RIGHT));
    assign stop        = tick && (state == RIGHT) && ((state_next == IDLE) || (state_next == DONE));

    always_ff @(posedge MCLK or negedge reset) begin
        if (!reset) begin
            ptr         <= '0;
            end_addr    <= '0;
            loaded      <= 1'b0;
            prefetched  <= 1'b0;
            rd_d1       <= 1'b0;
            sample_buf  <= '0;
            shreg       <= '0;
            bit_cnt     <= '0;
            MEM_ADDR    <= '0;
            MEM_RD      <= 1'b0;
            AUD_DACLRCK <= 1'b1;
            AUD_DACDAT  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef AUD_MONO_DUP_EN
            cur         <= '0;
`endif
        end else begin
            MEM_RD <= 1'b0;
            // read data is valid two edges after the strobe edge
            rd_d1  <= MEM_RD;
            if (rd_d1) sample_buf <= MEM_DATA;

            if (start) begin
                if (!loaded) begin
                    ptr      <= AUD_ADDR1;
                    end_addr <= AUD_ADDR2;
                    loaded   <= 1'b1;
                end
                if (state_next == PRIME) begin
                    MEM_RD   <= 1'b1;
                    MEM_ADDR <= loaded ? ptr : AUD_ADDR1;
                    busy     <= 1'b1;
                end else begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
            end

            if (enter_left) begin
                AUD_DACLRCK <= 1'b0;
                AUD_DACDAT  <= sample_buf[SAMPLE_W-1];
                shreg       <= sample_buf << 1;
                ptr         <= ptr + 1'b1;
                prefetched  <= 1'b0;
                bit_cnt     <= '0;
`ifdef AUD_MONO_DUP_EN
                cur         <= sample_buf;
`endif
            end

            if (shift) begin
                bit_cnt    <= bit_cnt + 1'b1;
                AUD_DACDAT <= shreg[SAMPLE_W-1];
                shreg      <= shreg << 1;
            end

            if (enter_right) begin
                bit_cnt     <= '0;
                AUD_DACLRCK <= 1'b1;
`ifdef AUD_MONO_DUP_EN
                AUD_DACDAT  <= cur[SAMPLE_W-1];
                shreg       <= cur << 1;
`else
                AUD_DACDAT  <= 1'b0;
                shreg       <= '0;
`endif
                if (enable && (ptr < end_addr)) begin
                    MEM_RD     <= 1'b1;
                    MEM_ADDR   <= ptr;
                    prefetched <= 1'b1;
                end
            end

            if (stop) begin
                bit_cnt    <= '0;
                AUD_DACDAT <= 1'b0;
                busy       <= 1'b0;
                if (state_next == DONE) done <= 1'b1;
            end

            if (tick && (state == DONE) && !enable) begin
                loaded <= 1'b0;
                done   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_aud_dac_player.sv
// Directed self-checking bench for aud_dac_player: table of playback ranges plus pause/resume and reset sequences.
// Expected right-half data follows AUD_MONO_DUP_EN when the bench is built with it.
module tb_aud_dac_player;

    localparam int SW = 16;
    localparam int AW = 18;

    logic          MCLK = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic [AW-1:0] AUD_ADDR1 = '0;
    logic [AW-1:0] AUD_ADDR2 = '0;
    logic [AW-1:0] MEM_ADDR;
    logic          MEM_RD;
    logic [SW-1:0] mem_q = '0;
    logic          AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, busy, done;

    logic [SW-1:0] mem [0:255];

    aud_dac_player #(.SAMPLE_W(SW), .ADDR_W(AW), .BCLK_DIV(48)) dut (
        .MCLK        (MCLK),
        .reset       (reset),
        .enable      (enable),
        .AUD_ADDR1   (AUD_ADDR1),
        .AUD_ADDR2   (AUD_ADDR2),
        .MEM_ADDR    (MEM_ADDR),
        .MEM_RD      (MEM_RD),
        .MEM_DATA    (mem_q),
        .AUD_BCLK    (AUD_BCLK),
        .AUD_DACLRCK (AUD_DACLRCK),
        .AUD_DACDAT  (AUD_DACDAT),
        .busy        (busy),
        .done        (done)
    );

    always #5 MCLK = ~MCLK;

    // one-cycle registered memory: data valid on the second edge after the strobe edge
    always @(posedge MCLK) if (MEM_RD) mem_q <= mem[MEM_ADDR[7:0]];

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // serial-stream monitor: codec-side view sampled on BCLK rising
    int            cyc = 0;
    logic          bclk_prev = 1'b0;
    logic          lrck_prev = 1'b1;
    int            bclk_rise = 0, bclk_period = 0, bclk_high = 0;
    int            lrck_falls = 0, lrck_fall_cyc = 0, lrck_period = 0;
    int            ln = 0, rn = 0, idle_bad = 0;
    logic [15:0]   lsh = '0, rsh = '0;
    logic [15:0]   frames_l[$], frames_r[$];
    logic [AW-1:0] rd_q[$];

    always @(negedge MCLK) begin
        cyc       <= cyc + 1;
        bclk_prev <= AUD_BCLK;
        lrck_prev <= AUD_DACLRCK;
        if (!reset) begin
            ln <= 0;
            rn <= 0;
        end else begin
            if (MEM_RD) rd_q.push_back(MEM_ADDR);
            if (AUD_BCLK && !bclk_prev) begin
                bclk_period <= cyc - bclk_rise;
                bclk_rise   <= cyc;
                if (!AUD_DACLRCK) begin
                    lsh <= {lsh[14:0], AUD_DACDAT};
                    ln  <= ln + 1;
                end else if (ln == 16) begin
                    if (rn == 15) begin
                        frames_l.push_back(lsh);
                        frames_r.push_back({rsh[14:0], AUD_DACDAT});
                        ln <= 0;
                        rn <= 0;
                    end else begin
                        rsh <= {rsh[14:0], AUD_DACDAT};
                        rn  <= rn + 1;
                    end
                end else if (AUD_DACDAT) begin
                    idle_bad <= idle_bad + 1;
                end
            end
            if (!AUD_BCLK && bclk_prev) bclk_high <= cyc - bclk_rise;
            if (!AUD_DACLRCK && lrck_prev) begin
                lrck_falls    <= lrck_falls + 1;
                lrck_period   <= cyc - lrck_fall_cyc;
                lrck_fall_cyc <= cyc;
            end
        end
    end

    task automatic wait_done(input int max_cyc, output int n);
        n = 0;
        while (done !== 1'b1 && n < max_cyc) begin
            @(negedge MCLK);
            n++;
        end
    endtask

    task automatic release_done(input string name);
        int n;
        enable = 1'b0;
        n = 0;
        while (done !== 1'b0 && n < 400) begin
            @(negedge MCLK);
            n++;
        end
        check(name, 32'(done), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bclk"},  32'(AUD_BCLK),    32'd0);
        check({tag, "_lrck"},  32'(AUD_DACLRCK), 32'd1);
        check({tag, "_dat"},   32'(AUD_DACDAT),  32'd0);
        check({tag, "_rd"},    32'(MEM_RD),      32'd0);
        check({tag, "_addr"},  32'(MEM_ADDR),    32'd0);
        check({tag, "_busy"},  32'(busy),        32'd0);
        check({tag, "_done"},  32'(done),        32'd0);
    endtask

    typedef struct {
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
        int            nrd;
        logic [15:0]   w_first;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, rd_base, fr_base, fall_base;
        logic [AW-1:0] ea;
        logic [15:0] exp_l, exp_r;

        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 16'hA5C3;
        mem[8'h11] = 16'h0001;
        mem[8'h12] = 16'hFFFF;
        mem[8'h20] = 16'h8000;
        mem[8'h21] = 16'h7FFF;
        mem[8'hFE] = 16'h1234;

        vecs[0] = '{a1: 18'h00010, a2: 18'h00013, nrd: 3, w_first: 16'hA5C3};
        vecs[1] = '{a1: 18'h00005, a2: 18'h00005, nrd: 0, w_first: 16'h0000};
        vecs[2] = '{a1: 18'h00020, a2: 18'h00022, nrd: 2, w_first: 16'h8000};
        vecs[3] = '{a1: 18'h00030, a2: 18'h0002F, nrd: 0, w_first: 16'h0000};
        vecs[4] = '{a1: 18'h3FFFE, a2: 18'h3FFFF, nrd: 1, w_first: 16'h1234};

        repeat (3) @(negedge MCLK);
        check_reset_outputs("reset");
        reset = 1'b1;

        repeat (200) @(negedge MCLK);
        check("bclk_period", 32'(bclk_period), 32'd48);
        check("bclk_high",   32'(bclk_high),   32'd24);

        for (int v = 0; v < 5; v++) begin
            rd_base   = rd_q.size();
            fr_base   = frames_l.size();
            fall_base = lrck_falls;
            @(negedge MCLK);
            AUD_ADDR1 = vecs[v].a1;
            AUD_ADDR2 = vecs[v].a2;
            enable    = 1'b1;
            wait_done((vecs[v].nrd + 1) * 1536 + 200, n);
            check($sformatf("v%0d_done", v), 32'(done), 32'd1);
            check($sformatf("v%0d_busy", v), 32'(busy), 32'd0);
            check($sformatf("v%0d_lrck", v), 32'(AUD_DACLRCK), 32'd1);
            check($sformatf("v%0d_reads", v), 32'(rd_q.size() - rd_base), 32'(vecs[v].nrd));
            check($sformatf("v%0d_frames", v), 32'(frames_l.size() - fr_base), 32'(vecs[v].nrd));
            check($sformatf("v%0d_lrck_falls", v), 32'(lrck_falls - fall_base), 32'(vecs[v].nrd));
            if (vecs[v].nrd == 0) begin
                check($sformatf("v%0d_done_latency", v), 32'(n <= 98), 32'd1);
            end else if (frames_l.size() - fr_base == vecs[v].nrd) begin
                check($sformatf("v%0d_first_word", v), 32'(frames_l[fr_base]), 32'(vecs[v].w_first));
            end
            if (vecs[v].nrd >= 2) check($sformatf("v%0d_lrck_period", v), 32'(lrck_period), 32'd1536);
            for (int i = 0; i < vecs[v].nrd; i++) begin
                ea = vecs[v].a1 + AW'(i);
                exp_l = mem[ea[7:0]];
`ifdef AUD_MONO_DUP_EN
                exp_r = exp_l;
`else
                exp_r = '0;
`endif
                if (rd_base + i < rd_q.size())
                    check($sformatf("v%0d_rd_addr%0d", v, i), 32'(rd_q[rd_base + i]), 32'(ea));
                if (fr_base + i < frames_l.size()) begin
                    check($sformatf("v%0d_left%0d", v, i),  32'(frames_l[fr_base + i]), 32'(exp_l));
                    check($sformatf("v%0d_right%0d", v, i), 32'(frames_r[fr_base + i]), 32'(exp_r));
                end
            end
            release_done($sformatf("v%0d_done_clear", v));
        end

        // pause during LEFT of 0x11, change addresses while paused, then resume
        rd_base   = rd_q.size();
        fr_base   = frames_l.size();
        fall_base = lrck_falls;
        @(negedge MCLK);
        AUD_ADDR1 = 18'h10;
        AUD_ADDR2 = 18'h13;
        enable    = 1'b1;
        n = 0;
        while (lrck_falls - fall_base < 2 && n < 4000) begin
            @(negedge MCLK);
            n++;
        end
        check("pause_reach_left2", 32'(lrck_falls - fall_base), 32'd2);
        repeat (50) @(negedge MCLK);
        enable    = 1'b0;
        AUD_ADDR1 = 18'h40;
        AUD_ADDR2 = 18'h50;
        n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            @(negedge MCLK);
            n++;
        end
        check("pause_busy",   32'(busy), 32'd0);
        check("pause_done",   32'(done), 32'd0);
        check("pause_frames", 32'(frames_l.size() - fr_base), 32'd2);
        repeat (300) @(negedge MCLK);
        check("pause_reads",  32'(rd_q.size() - rd_base), 32'd2);
        check("pause_lrck",   32'(AUD_DACLRCK), 32'd1);
        enable = 1'b1;
        wait_done(3500, n);
        check("resume_done",  32'(done), 32'd1);
        check("resume_reads", 32'(rd_q.size() - rd_base), 32'd3);
        if (rd_q.size() - rd_base == 3) check("resume_addr", 32'(rd_q[rd_base + 2]), 32'h12);
        if (frames_l.size() - fr_base == 3) check("resume_word", 32'(frames_l[fr_base + 2]), 32'hFFFF);
        release_done("resume_done_clear");

        // reset in the middle of LEFT, then a fresh play must relatch the addresses
        fall_base = lrck_falls;
        @(negedge MCLK);
        AUD_ADDR1 = 18'h20;
        AUD_ADDR2 = 18'h22;
        enable    = 1'b1;
        n = 0;
        while (lrck_falls - fall_base < 1 && n < 2000) begin
            @(negedge MCLK);
            n++;
        end
        check("rst_reach_left", 32'(AUD_DACLRCK), 32'd0);
        repeat (100) @(negedge MCLK);
        #2 reset = 1'b0;
        #1 check_reset_outputs("midrst");
        AUD_ADDR1 = 18'h10;
        AUD_ADDR2 = 18'h13;
        repeat (4) @(negedge MCLK);
        rd_base = rd_q.size();
        fr_base = frames_l.size();
        reset = 1'b1;
        wait_done(5000, n);
        check("relatch_done",   32'(done), 32'd1);
        check("relatch_reads",  32'(rd_q.size() - rd_base), 32'd3);
        if (rd_q.size() > rd_base) check("relatch_addr", 32'(rd_q[rd_base]), 32'h10);
        if (frames_l.size() > fr_base) check("relatch_word", 32'(frames_l[fr_base]), 32'hA5C3);
        release_done("relatch_done_clear");

        check("idle_dat_zero", 32'(idle_bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
